lsu: RTL and testbench
======================

# lsu

Load/store unit sitting between the CPU execute stage and the byte-addressed data memory. Accepts one byte, halfword or word request at a time and turns it into word-aligned accesses on the memory port. Sub-word stores use read-modify-write, because the memory only writes whole words. Load data is extracted, byte-lane corrected and sign/zero-extended before it is returned to the core.

## Interface
- No parameters; the memory port is fixed at 32-bit address and data.
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- req_unsigned  input  1  zero-extend loads when 1
- req_addr  input  32  byte address
- req_wdata  input  32  store data, LSB-justified
- resp_valid  output  1  one-cycle pulse, request complete
- resp_rdata  output  32  load result (0 for stores)
- resp_err  output  1  misaligned request, qualified by resp_valid
- mem_addr  output  32  word-aligned address to data memory ({addr[31:2],2'b00})
- mem_wdata  output  32  word to write
- mem_wen  output  1  write enable, one cycle per write
- mem_dout  input  32  combinational read data from the data memory

## Operation
- Memory lane convention:
  - Memory returns byte addr+0 in mem_dout[31:24] and addr+3 in [7:0].
  - Memory stores mem_wdata[7:0] at addr+0 and [31:24] at addr+3.
  - The LSU byte-reverses mem_dout into a little-endian word W (W[7:0] = byte addr+0) before any use. Writes are issued little-endian, unswapped.
- Lane select uses off = addr[1:0].
  - Byte: W[8*off +: 8].
  - Half: W[16*addr[1] +: 16].
  - Word: W.
- Loads are sign-extended unless req_unsigned=1.
- Store merge: the old word W is read, the target lanes are replaced with the low bytes of req_wdata, and the merged word is written.
- Request fields are registered on acceptance (req_valid && req_ready). Inputs are ignored at all other times.
- FSM states: IDLE, ACCESS, WRITE, RESP.
  - IDLE: req_ready=1. On accept, go to ACCESS, or to RESP with err=1 if misaligned (see Configuration).
  - ACCESS, load: capture the extracted result, then go to RESP.
  - ACCESS, word store: mem_wen=1 with req_wdata, then go to RESP.
  - ACCESS, sub-word store: capture W, then go to WRITE.
  - WRITE: mem_wen=1 with the merged word, then go to RESP.
  - RESP: resp_valid=1 for one cycle, then go to IDLE.
- A misaligned request never asserts mem_wen and never changes memory.
- mem_addr holds the registered aligned address in every state (0 after reset until the first accept). mem_wen is 1 only in the states listed above.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_wen=0, mem_addr=0, mem_wdata=0, state=IDLE.
- Reset asserted mid-operation aborts the access immediately.
  - mem_wen drops asynchronously.
  - A write in flight at the reset edge may or may not have landed; no partial merge is retried.
- Latency, accept edge = cycle 0:
  - load / word store: resp_valid in cycle 2
  - sub-word store: resp_valid in cycle 3
  - misaligned: resp_valid in cycle 1
- resp_valid has no backpressure; the core must sample it in that cycle.
- Back-to-back: the next request is accepted in the cycle after RESP, when IDLE is reached.
- Minimum request spacing: 3 cycles for load / word store, 4 cycles for sub-word store.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - Half with addr[0]=1, or word with addr[1:0]!=0, goes to RESP with resp_err=1, resp_rdata=0 and no memory access.
- LSU_MISALIGN_TRAP_EN undefined:
  - No check is made. The low address bits below the access size are ignored: a half uses addr[1]; a word uses off=0.
  - resp_err is tied to 0.

## Structure
- lsu_pkg holds:
  - size enum: SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10
  - state enum: IDLE, ACCESS, WRITE, RESP
  - byte-swap function used on mem_dout
- One sub-module, lsu_lane: purely combinational.
  - Inputs: W, off, size, unsigned, wdata.
  - Outputs: extended load value, merged store word.
- The FSM and all registers stay in lsu.

## Test plan
- Word store 0xDEADBEEF @0x100, then word load @0x100 -> resp_rdata=0xDEADBEEF, resp_valid at cycle 2 after each accept.
- Memory word @0x200 = 0x11223344 (LE); byte store 0xAA @0x201 -> exactly one mem_wen, word becomes 0x1122AA44; load byte @0x201 signed -> 0xFFFFFFAA, unsigned -> 0x000000AA.
- Half store 0x8001 @0x202, then half load signed @0x202 -> 0xFFFF8001; bytes @0x200/0x201 unchanged.
- With LSU_MISALIGN_TRAP_EN: word store @0x103 -> resp_err=1 at cycle 1, mem_wen never asserted, memory unchanged. Without the macro: the same request writes @0x100 and resp_err=0.
- Reset asserted in WRITE state -> mem_wen=0 and req_ready=1 immediately; the next load completes normally.
- Back-to-back 8 random requests checked against a reference memory model; req_ready low during every busy cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Optional feature: LSU_MISALIGN_TRAP_EN enables misaligned-request trapping in lsu.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE,
    RESP
  } state_e;

  // Memory returns addr+0 in the top byte; flip to little-endian lane order.
  function automatic logic [31:0] bswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // The reserved encoding behaves as a word access.
  function automatic size_e norm_size(input logic [1:0] s);
    case (s)
      2'b00:   return SIZE_B;
      2'b01:   return SIZE_H;
      default: return SIZE_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e s, input logic [1:0] off);
    return ((s == SIZE_H) && off[0]) || ((s == SIZE_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response and data-memory signals of the load/store unit.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic [31:0] mem_dout;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_dout,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_wen
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_wen
  );
endinterface

// File: rtl/lsu_lane.sv
// Combinational lane logic: load extraction/extension and store merge on a little-endian word.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] w_i,
  input  logic [1:0]  off_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halves ignore off[0]; words ignore the offset entirely.
  assign byte_sel = w_i[{off_i, 3'b000} +: 8];
  assign half_sel = w_i[{off_i[1], 4'b0000} +: 16];

  always_comb begin
    load_o  = w_i;
    merge_o = wdata_i;
    case (size_i)
      SIZE_B: begin
        load_o  = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
        merge_o = w_i;
        merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SIZE_H: begin
        load_o  = {{16{~unsigned_i & half_sel[15]}}, half_sel};
        merge_o = w_i;
        merge_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: begin
        load_o  = w_i;
        merge_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, word-aligned memory accesses, read-modify-write for sub-word stores.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word requests with resp_err.
module lsu
  import lsu_pkg::*;
(
  input logic clk,
  input logic rst,
  lsu_if.slave bus
);

  state_e      state_q, state_d;
  logic        we_q;
  size_e       size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] merge_q, merge_d;
  logic        err_q;
  logic        accept;
  logic        misalign;
  logic        wen;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  assign accept = bus.req_valid && (state_q == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = is_misaligned(norm_size(bus.req_size), bus.req_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  lsu_lane u_lane (
    .w_i        (bswap32(bus.mem_dout)),
    .off_i      (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .load_o     (load_val),
    .merge_o    (merge_val)
  );

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    merge_d = merge_q;
    wen     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          rdata_d = 32'h0;
          state_d = misalign ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (!we_q) begin
          rdata_d = load_val;
          state_d = RESP;
        end else if (size_q == SIZE_W) begin
          wen     = 1'b1;
          state_d = RESP;
        end else begin
          merge_d = merge_val;
          state_d = WRITE;
        end
      end
      WRITE: begin
        wen     = 1'b1;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= SIZE_B;
      uns_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      merge_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      merge_q <= merge_d;
      if (accept) begin
        we_q    <= bus.req_we;
        size_q  <= norm_size(bus.req_size);
        uns_q   <= bus.req_unsigned;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        err_q   <= misalign;
      end
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.mem_addr   = {addr_q[31:2], 2'b00};
  assign bus.mem_wen    = wen;
  // Word stores go out straight from the request; sub-word stores use the merged word.
  assign bus.mem_wdata  = wen ? ((state_q == WRITE) ? merge_q : wdata_q) : 32'h0;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus random back-to-back requests against a byte-array model.
module tb_lsu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_if bus ();

  lsu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int failures = 0;
  int wen_cnt = 0;
  logic init_req = 1'b0;

  logic [7:0] dmem    [1024];
  logic [7:0] ref_mem [1024];
  logic [9:0] ma;

  // Data memory as seen by the DUT: addr+0 comes back in the top byte.
  assign ma = {bus.mem_addr[9:2], 2'b00};
  assign bus.mem_dout = {dmem[ma], dmem[ma + 10'd1], dmem[ma + 10'd2], dmem[ma + 10'd3]};

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 1024; i++) dmem[i] <= ref_mem[i];
    end else if (bus.mem_wen) begin
      dmem[ma]         <= bus.mem_wdata[7:0];
      dmem[ma + 10'd1] <= bus.mem_wdata[15:8];
      dmem[ma + 10'd2] <= bus.mem_wdata[23:16];
      dmem[ma + 10'd3] <= bus.mem_wdata[31:24];
      wen_cnt <= wen_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    return {ref_mem[a + 3], ref_mem[a + 2], ref_mem[a + 1], ref_mem[a]};
  endfunction

  // Issue one request, check latency, busy-ready, write count and response against the model.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit b2b);
    int sz, ea, nb, exp_lat, exp_wen, waits, lat, w0;
    logic mis;
    logic [31:0] exp_rd;
    bit accepted, done;

    sz  = (size == 2'd3) ? 2 : int'(size);
    mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = (sz == 1 && addr[0]) || (sz == 2 && addr[1:0] != 2'b00);
`endif
    nb = 1 << sz;
    ea = int'(addr[9:0]) & ~(nb - 1);
    exp_rd = 32'h0;
    if (!mis && !we) begin
      for (int k = 0; k < nb; k++) exp_rd = exp_rd | (32'(ref_mem[ea + k]) << (8 * k));
      if (!uns && sz == 0 && exp_rd[7])  exp_rd = exp_rd | 32'hFFFF_FF00;
      if (!uns && sz == 1 && exp_rd[15]) exp_rd = exp_rd | 32'hFFFF_0000;
    end
    if (!mis && we) begin
      for (int k = 0; k < nb; k++) ref_mem[ea + k] = wdata[8 * k +: 8];
    end
    exp_lat = mis ? 1 : ((we && sz < 2) ? 3 : 2);
    exp_wen = (!mis && we) ? 1 : 0;

    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;

    accepted = 0;
    waits = 0;
    w0 = 0;
    for (int t = 0; t < 20 && !accepted; t++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        w0 = wen_cnt;
        accepted = 1;
      end else begin
        waits++;
      end
    end
    if (!accepted) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    if (b2b) check("b2b_ready", waits, 0);
    @(posedge clk);
    #1;
    // Scramble the request fields: the unit must rely on its registered copy.
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'($urandom);
    bus.req_size     = 2'($urandom);
    bus.req_unsigned = 1'($urandom);
    bus.req_addr     = $urandom;
    bus.req_wdata    = $urandom;

    done = 0;
    lat = 0;
    for (int n = 1; n <= 10 && !done; n++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = n;
        done = 1;
      end else begin
        check("busy_ready", 32'(bus.req_ready), 32'd0);
      end
    end
    if (!done) begin
      check("resp_timeout", 32'd0, 32'd1);
      return;
    end
    check("ready_in_resp", 32'(bus.req_ready), 32'd0);
    check("latency", lat, exp_lat);
    check("wen_count", wen_cnt - w0, exp_wen);
    check("resp_err", 32'(bus.resp_err), 32'(mis));
    check("resp_rdata", bus.resp_rdata, exp_rd);
    $display("txn we=%0d size=%0d uns=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
             we, size, uns, addr, wdata, bus.resp_rdata, bus.resp_err, lat);
  endtask

  initial begin
    int bad;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;

    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
    ref_mem[32'h200] = 8'h44;
    ref_mem[32'h201] = 8'h33;
    ref_mem[32'h202] = 8'h22;
    ref_mem[32'h203] = 8'h11;
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    @(negedge clk);

    check("rst_ready",  32'(bus.req_ready), 32'd1);
    check("rst_valid",  32'(bus.resp_valid), 32'd0);
    check("rst_rdata",  bus.resp_rdata, 32'h0);
    check("rst_err",    32'(bus.resp_err), 32'd0);
    check("rst_wen",    32'(bus.mem_wen), 32'd0);
    check("rst_addr",   bus.mem_addr, 32'h0);
    check("rst_wdata",  bus.mem_wdata, 32'h0);
    rst = 1'b0;

    do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1);
    check("word_load_dir", bus.resp_rdata, 32'hDEAD_BEEF);

    do_req(1'b1, 2'd0, 1'b0, 32'h201, 32'h0000_00AA, 1);
    do_req(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 1);
    check("byte_merge_dir", bus.resp_rdata, 32'h1122_AA44);
    do_req(1'b0, 2'd0, 1'b0, 32'h201, 32'h0, 1);
    check("byte_signed_dir", bus.resp_rdata, 32'hFFFF_FFAA);
    do_req(1'b0, 2'd0, 1'b1, 32'h201, 32'h0, 1);
    check("byte_unsigned_dir", bus.resp_rdata, 32'h0000_00AA);

    do_req(1'b1, 2'd1, 1'b0, 32'h202, 32'h1234_8001, 1);
    do_req(1'b0, 2'd1, 1'b0, 32'h202, 32'h0, 1);
    check("half_signed_dir", bus.resp_rdata, 32'hFFFF_8001);
    do_req(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 1);
    check("half_merge_dir", bus.resp_rdata, 32'h8001_AA44);

    do_req(1'b1, 2'd2, 1'b0, 32'h103, 32'h5566_7788, 1);
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1);

    // Reset while the merged word is being written.
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b1;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h301;
    bus.req_wdata    = 32'h0000_0077;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("write_wen", 32'(bus.mem_wen), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_wen",   32'(bus.mem_wen), 32'd0);
    check("abort_ready", 32'(bus.req_ready), 32'd1);
    check("abort_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_req(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 0);
    do_req(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 1);

    for (int r = 0; r < 8; r++) begin
      do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
             32'($urandom_range(0, 1023)), $urandom, 1);
    end

    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 1024; i++) if (dmem[i] !== ref_mem[i]) bad++;
    check("mem_image", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
